// File: rtl/enemy_path_ctl.sv
// enemy_path_ctl: per-enemy controller that walks a waypoint path at a
// programmable step rate, requests shots periodically, dies on a collision
// hit and respawns at the start of the path after a fixed number of steps.
// The waypoint tables come in as packed parameters, with waypoint i in
// bits [i*12 +: 12]. The build flow fills them from enID_x.txt and
// enID_y.txt. The default tables are a flat path derived from ID.
`timescale 1ns/1ps
module enemy_path_ctl #(
    parameter int unsigned ID            = 1,
    parameter int unsigned PATH_LEN      = 152,
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned STEP_DIV      = 1000000,
    parameter int unsigned SHOT_PERIOD   = 64,
    parameter int unsigned RESPAWN_STEPS = 128,
    parameter logic [PATH_LEN*12-1:0] X_PATH = {PATH_LEN{12'(ID)}},
    parameter logic [PATH_LEN*12-1:0] Y_PATH = {PATH_LEN{12'(ID)}}
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              en,
    input  logic              hit,
    output logic [11:0]       xpos_out,
    output logic [11:0]       ypos_out,
    output logic              alive,
    output logic              shot,
    output logic              kill,
    output logic [ADDR_W-1:0] step_idx
);

    localparam int DIV_W  = $clog2(STEP_DIV);
    localparam int SHOT_W = (SHOT_PERIOD > 1) ? $clog2(SHOT_PERIOD) : 1;
    localparam int DEAD_W = (RESPAWN_STEPS > 1) ? $clog2(RESPAWN_STEPS) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(STEP_DIV - 1);
    localparam logic [SHOT_W-1:0] SHOT_LAST = SHOT_W'(SHOT_PERIOD - 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(RESPAWN_STEPS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PATH_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIVE = 2'd1,
        S_DEAD  = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DIV_W-1:0]  div_q;
    logic [SHOT_W-1:0] shot_cnt_q;
    logic [DEAD_W-1:0] dead_q;
    logic [11:0]       xpos_q;
    logic [11:0]       ypos_q;
    logic              alive_q;
    logic              shot_q;
    logic              kill_q;

    logic [11:0]       xpos_d;
    logic [11:0]       ypos_d;
    logic              tick;

    // Read-only waypoint tables unpacked from the parameter vectors.
    logic [11:0] xrom [PATH_LEN];
    logic [11:0] yrom [PATH_LEN];

    for (genvar i = 0; i < PATH_LEN; i++) begin : g_rom
        assign xrom[i] = X_PATH[i*12 +: 12];
        assign yrom[i] = Y_PATH[i*12 +: 12];
    end

    // Waypoint lookup for the current address. Addresses past the end of the path read as 0.
    always_comb begin
        xpos_d = '0;
        ypos_d = '0;
        for (int i = 0; i < PATH_LEN; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                xpos_d = xrom[i];
                ypos_d = yrom[i];
            end
        end
    end

    // One step tick per STEP_DIV enabled cycles once the enemy is in play.
    assign tick = en && (state_q != S_IDLE) && (div_q == DIV_LAST);

    // Main controller: step divider, path walk, shot cadence, death/respawn and registered outputs.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            div_q      <= '0;
            shot_cnt_q <= '0;
            dead_q     <= '0;
            xpos_q     <= '0;
            ypos_q     <= '0;
            alive_q    <= 1'b0;
            shot_q     <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            shot_q  <= 1'b0;
            kill_q  <= 1'b0;
            alive_q <= (state_q == S_ALIVE);
            // Position tracks the path only while alive. Otherwise it keeps the last drawn spot.
            if (state_q == S_ALIVE) begin
                xpos_q <= xpos_d;
                ypos_q <= ypos_d;
            end
            if (en) begin
                if (state_q != S_IDLE) begin
                    div_q <= tick ? '0 : div_q + DIV_W'(1);
                end
                unique case (state_q)
                    S_IDLE: begin
                        state_q <= S_ALIVE;
                        addr_q  <= '0;
                        div_q   <= '0;
                    end
                    S_ALIVE: begin
                        // A hit wins over a coincident tick: no advance, no shot.
                        if (hit) begin
                            state_q    <= S_DEAD;
                            kill_q     <= 1'b1;
                            dead_q     <= '0;
                            shot_cnt_q <= '0;
                        end else if (tick) begin
                            addr_q <= (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
                            if (shot_cnt_q == SHOT_LAST) begin
                                shot_cnt_q <= '0;
                                shot_q     <= 1'b1;
                            end else begin
                                shot_cnt_q <= shot_cnt_q + SHOT_W'(1);
                            end
                        end
                    end
                    S_DEAD: begin
                        if (tick) begin
                            if (dead_q == DEAD_LAST) begin
                                state_q    <= S_ALIVE;
                                addr_q     <= '0;
                                shot_cnt_q <= '0;
                                div_q      <= '0;
                                dead_q     <= '0;
                            end else begin
                                dead_q <= dead_q + DEAD_W'(1);
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign xpos_out = xpos_q;
    assign ypos_out = ypos_q;
    assign alive    = alive_q;
    assign shot     = shot_q;
    assign kill     = kill_q;
    assign step_idx = addr_q;

endmodule

// File: tb/tb_enemy_path_ctl.sv
// Testbench for enemy_path_ctl: a short 5-waypoint path with a 4-cycle step,
// a shot every 3 steps and a 2-step respawn delay.
`timescale 1ns/1ps
module tb_enemy_path_ctl;

    localparam int P_LEN = 5;
    localparam int SDIV  = 4;
    localparam int SPER  = 3;
    localparam int RESP  = 2;

    logic       pclk = 1'b0;
    logic       rst;
    logic       en;
    logic       hit;
    logic [11:0] xpos_out;
    logic [11:0] ypos_out;
    logic       alive;
    logic       shot;
    logic       kill;
    logic [2:0] step_idx;

    int XT [P_LEN] = '{10, 20, 30, 40, 50};
    int YT [P_LEN] = '{1, 2, 3, 4, 5};

    int n_pass = 0;
    int n_tot  = 0;
    int nn     = 0;

    enemy_path_ctl #(
        .ID(1), .PATH_LEN(P_LEN), .ADDR_W(3), .STEP_DIV(SDIV),
        .SHOT_PERIOD(SPER), .RESPAWN_STEPS(RESP),
        .X_PATH({12'd50, 12'd40, 12'd30, 12'd20, 12'd10}),
        .Y_PATH({12'd5, 12'd4, 12'd3, 12'd2, 12'd1})
    ) dut (
        .pclk(pclk), .rst(rst), .en(en), .hit(hit),
        .xpos_out(xpos_out), .ypos_out(ypos_out), .alive(alive),
        .shot(shot), .kill(kill), .step_idx(step_idx)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input int got, input int exp);
        n_tot++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    task automatic go(input int k);
        while (nn < k) begin
            @(negedge pclk);
            nn++;
        end
    endtask

    // Behavioural model: mode plus plain counts of enabled cycles, steps
    // taken in the current life and steps spent dead.
    int m_mode = 0;      // 0 waiting, 1 alive, 2 dead
    int m_cyc = 0, m_steps = 0, m_dead = 0;
    int m_x = 0, m_y = 0, m_alive = 0, m_shot = 0, m_kill = 0;
    int o_mode, o_addr;
    bit m_tick;

    initial forever begin
        @(posedge pclk or posedge rst);
        if (rst) begin
            m_mode = 0; m_cyc = 0; m_steps = 0; m_dead = 0;
            m_x = 0; m_y = 0; m_alive = 0; m_shot = 0; m_kill = 0;
        end else begin
            o_mode  = m_mode;
            o_addr  = m_steps % P_LEN;
            m_shot  = 0;
            m_kill  = 0;
            m_alive = (o_mode == 1) ? 1 : 0;
            if (o_mode == 1) begin
                m_x = XT[o_addr];
                m_y = YT[o_addr];
            end
            if (en) begin
                m_tick = (o_mode != 0) && (m_cyc % SDIV == SDIV - 1);
                if (o_mode != 0) m_cyc++;
                if (o_mode == 0) begin
                    m_mode = 1; m_cyc = 0; m_steps = 0;
                end else if (o_mode == 1) begin
                    if (hit) begin
                        m_mode = 2; m_kill = 1; m_dead = 0;
                    end else if (m_tick) begin
                        m_steps++;
                        if (m_steps % SPER == 0) m_shot = 1;
                    end
                end else if (m_tick) begin
                    m_dead++;
                    if (m_dead == RESP) begin
                        m_mode = 1; m_steps = 0; m_cyc = 0;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, just after each edge.
    initial forever begin
        @(posedge pclk);
        #1;
        chk("m_xpos", int'(xpos_out), m_x);
        chk("m_ypos", int'(ypos_out), m_y);
        chk("m_alive", int'(alive), m_alive);
        chk("m_shot", int'(shot), m_shot);
        chk("m_kill", int'(kill), m_kill);
        chk("m_step_idx", int'(step_idx), m_steps % P_LEN);
    end

    initial begin
        #50000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int idx_seq [6] = '{0, 1, 2, 3, 4, 0};
    int x_seq   [6] = '{10, 20, 30, 40, 50, 10};
    int nshot, nkill;

    initial begin
        rst = 1'b1; en = 1'b0; hit = 1'b0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        chk("rst_x", int'(xpos_out), 0);
        chk("rst_y", int'(ypos_out), 0);
        chk("rst_alive", int'(alive), 0);
        chk("rst_shot", int'(shot), 0);
        chk("rst_kill", int'(kill), 0);
        chk("rst_step", int'(step_idx), 0);
        rst = 1'b0;
        nn = 0;
        en = 1'b1;

        // Path walk and shot cadence over the first 9 ticks.
        nshot = 0;
        for (int k = 1; k <= 37; k++) begin
            go(k);
            if (shot) nshot++;
            if (k == 1) chk("alive_lag", int'(alive), 0);
            if (k == 2) chk("first_y", int'(ypos_out), 1);
            if (k <= 21 && (k - 1) % 4 == 0) chk("step_seq", int'(step_idx), idx_seq[(k - 1) / 4]);
            if (k <= 22 && k >= 2 && (k - 2) % 4 == 0) chk("x_seq", int'(xpos_out), x_seq[(k - 2) / 4]);
            if (k == 13 || k == 25 || k == 37) chk("shot_tick", int'(shot), 1);
        end
        chk("shot_count9", nshot, 3);

        // Hit at step_idx 2 coinciding with what would be a shot tick.
        go(72); hit = 1'b1;
        go(73); hit = 1'b0;
        chk("hit_kill", int'(kill), 1);
        chk("hit_noshot", int'(shot), 0);
        chk("hit_step", int'(step_idx), 2);
        chk("hit_x", int'(xpos_out), 30);
        go(74);
        chk("dead_alive", int'(alive), 0);
        chk("dead_kill1", int'(kill), 0);
        chk("dead_x", int'(xpos_out), 30);

        // Respawn after 2 dead ticks, then the first shot 3 ticks later.
        go(81);
        chk("respawn_step", int'(step_idx), 0);
        go(82);
        chk("respawn_alive", int'(alive), 1);
        chk("respawn_x", int'(xpos_out), 10);
        nshot = 0;
        for (int k = 83; k <= 92; k++) begin
            go(k);
            if (shot) nshot++;
        end
        chk("respawn_noshot", nshot, 0);
        go(93);
        chk("respawn_shot", int'(shot), 1);
        chk("respawn_step3", int'(step_idx), 3);

        // Freeze for 10 cycles with a hit pulse in the gap.
        go(94); en = 1'b0;
        nkill = 0;
        for (int k = 95; k <= 104; k++) begin
            go(k);
            if (kill) nkill++;
            if (k == 98) hit = 1'b1;
            if (k == 99) hit = 1'b0;
        end
        chk("gap_nokill", nkill, 0);
        chk("gap_step", int'(step_idx), 3);
        chk("gap_alive", int'(alive), 1);
        en = 1'b1;
        go(106);
        chk("resume_hold", int'(step_idx), 3);
        go(107);
        chk("resume_tick", int'(step_idx), 4);
        go(114);
        chk("resume_noshot", int'(shot), 0);
        go(115);
        chk("resume_shot", int'(shot), 1);

        // Kill, then reset asynchronously while dead.
        go(116); hit = 1'b1;
        go(117); hit = 1'b0;
        chk("kill2", int'(kill), 1);
        go(118);
        chk("dead2_alive", int'(alive), 0);
        #2;
        rst = 1'b1;
        en  = 1'b0;
        #1;
        chk("arst_x", int'(xpos_out), 0);
        chk("arst_y", int'(ypos_out), 0);
        chk("arst_alive", int'(alive), 0);
        chk("arst_shot", int'(shot), 0);
        chk("arst_kill", int'(kill), 0);
        chk("arst_step", int'(step_idx), 0);
        go(119);
        rst = 1'b0;
        go(122);
        chk("idle_alive", int'(alive), 0);
        chk("idle_step", int'(step_idx), 0);
        en = 1'b1;
        go(123);
        chk("restart_lag", int'(alive), 0);
        go(124);
        chk("restart_alive", int'(alive), 1);
        chk("restart_x", int'(xpos_out), 10);
        go(128);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/enemy_path_ctl.md
Name: enemy_path_ctl

Overview:
Per-enemy motion and fire controller. Walks a stored waypoint path (X and Y tables, depth PATH_LEN) at a programmable step rate, fires periodically, dies on a collision hit and respawns at path start after a delay. One instance per enemy feeds the enemy sprite drawer, the enemy bullet spawner and the score counter.

Parameters:
ID, 1, selects path data set: files enID_x.txt / enID_y.txt, binary, one 12-bit word per line.
PATH_LEN, 152, waypoints in path; legal 2..4096.
ADDR_W, 8, waypoint address width; must satisfy 2^ADDR_W >= PATH_LEN.
STEP_DIV, 1000000, pclk cycles per path step; legal >= 2.
SHOT_PERIOD, 64, path steps between shots; legal >= 1.
RESPAWN_STEPS, 128, step ticks spent dead before respawn; legal >= 1.

Ports:
pclk  in  1  clock.
rst  in  1  asynchronous reset, active-high.
en  in  1  game running; low freezes all counters and state.
hit  in  1  single-cycle collision pulse from the player bullet collision logic.
xpos_out  out  12  enemy X position.
ypos_out  out  12  enemy Y position.
alive  out  1  enemy is visible and collidable.
shot  out  1  single-cycle fire request.
kill  out  1  single-cycle pulse on death, used for scoring.
step_idx  out  ADDR_W  current waypoint address.

Behaviour:
- Reset (async assert, sync release): state=IDLE; addr, div_cnt, shot_cnt and dead_cnt = 0; xpos_out, ypos_out, alive, shot and kill = 0.
- Path ROM: two arrays of PATH_LEN x 12 bits, loaded at elaboration. Contents are never written.
- Tick: div_cnt counts 0..STEP_DIV-1 while en=1 and state != IDLE. tick=1 in the cycle div_cnt==STEP_DIV-1; div_cnt wraps to 0 on that edge. Exactly one tick per STEP_DIV enabled cycles.
- States: IDLE, ALIVE, DEAD.
- IDLE: en=1 moves to ALIVE on the next edge with addr=0 and div_cnt=0.
- ALIVE, on tick:
  - addr increments; at addr==PATH_LEN-1 it wraps to 0.
  - shot_cnt increments; at shot_cnt==SHOT_PERIOD-1 it wraps to 0 and shot=1 for that next cycle.
- ALIVE, on hit=1:
  - DEAD next edge; kill=1 for one cycle; dead_cnt=0; shot_cnt=0.
  - Hit has priority over tick in the same cycle: no address advance and no shot.
- DEAD, on tick: dead_cnt increments. At dead_cnt==RESPAWN_STEPS-1, go to ALIVE with addr=0, shot_cnt=0 and div_cnt=0. hit is ignored in DEAD and IDLE.
- Position outputs:
  - In ALIVE, xpos_out <= xrom[addr] and ypos_out <= yrom[addr] every cycle: 1-cycle latency from addr.
  - In DEAD and IDLE, outputs hold their last value.
- Registered outputs: alive is registered (state==ALIVE). shot and kill are registered pulses, never high for more than 1 consecutive cycle.
- en=0: all counters, addr and state hold; shot and kill forced 0. A hit arriving while en=0 is ignored. Resuming with en=1 continues exactly where the block stopped.
- step_idx = addr.
- Reset asserted mid-operation returns the block to the reset values immediately, regardless of state.
- Widths: div_cnt is ceil(log2(STEP_DIV)) bits; shot_cnt and dead_cnt are sized to their limits. No counter is allowed to overflow past its limit.

Test Plan:
Bench parameters: STEP_DIV=4, PATH_LEN=5, SHOT_PERIOD=3, RESPAWN_STEPS=2; path X = 10,20,30,40,50; path Y = 1,2,3,4,5.
- Reset, then en=1 -> alive=1 one cycle after ALIVE is entered; xpos_out=10 and ypos_out=1; step_idx advances every 4 cycles as 0,1,2,3,4,0 (wrap after 4); xpos_out follows 1 cycle later.
- Run 9 ticks while alive -> shot pulses exactly at ticks 3, 6 and 9, each 1 cycle wide.
- Pulse hit at step_idx=2 in the same cycle as a tick -> kill=1 for 1 cycle; alive=0; step_idx stays 2; no shot; xpos_out holds 30.
- Keep running after the death -> after 2 ticks alive=1 and step_idx=0; xpos_out=10 the next cycle; the next shot occurs 3 ticks later.
- Drop en for 10 cycles mid-count, with a hit pulse during the gap -> the hit is ignored; step_idx, div_cnt and shot_cnt are frozen; timing resumes unchanged when en returns.
- Assert rst asynchronously while DEAD -> all outputs 0 before the next pclk edge; IDLE until en=1.
